// File: rtl/booth_issue_ctrl.sv
// Operand FIFO and one-job-at-a-time issue sequencer for the sequential Booth multiplier.
// Optional WAIT watchdog compiled in with `define BOOTH_TIMEOUT_EN.
module booth_issue_ctrl #(
  parameter int N        = 8,
  parameter int DEPTH    = 4,
  parameter int TO_SLACK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_y,
  output logic             mul_start,
  output logic [N-1:0]     mul_x,
  output logic [N-1:0]     mul_y,
  input  logic             mul_done,
  input  logic [2*N-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic             out_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next;

  logic [N-1:0]     r_mem_x [DEPTH];
  logic [N-1:0]     r_mem_y [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_to_hit;

  logic [N-1:0]     r_mul_x;
  logic [N-1:0]     r_mul_y;
  logic             r_out_valid;
  logic [2*N-1:0]   r_out_p;
  logic             r_out_err;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = (r_state == S_ISSUE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wptr[AW-1:0]] <= in_x;
      r_mem_y[r_wptr[AW-1:0]] <= in_y;
    end
  end

`ifdef BOOTH_TIMEOUT_EN
  localparam int CW = $clog2(N + TO_SLACK + 1);
  logic [CW-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (reset)                  r_to_cnt <= '0;
    else if (r_state == S_ISSUE) r_to_cnt <= '0;
    else if (r_state == S_WAIT)  r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Fires in the last allowed WAIT cycle so HOLD follows exactly N+TO_SLACK WAIT cycles.
  assign w_to_hit = (r_state == S_WAIT) && (r_to_cnt == CW'(N + TO_SLACK - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mul_done || w_to_hit) w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = w_empty ? S_IDLE : S_ISSUE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mul_start = (r_state == S_ISSUE);
    in_ready  = !w_full;
  end

  // Operands load on entry to ISSUE so they are already stable while mul_start is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_x <= '0;
      r_mul_y <= '0;
    end else if (w_next == S_ISSUE) begin
      r_mul_x <= r_mem_x[r_rptr[AW-1:0]];
      r_mul_y <= r_mem_y[r_rptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_out_err   <= 1'b0;
    end else if (r_state == S_WAIT && mul_done) begin
      r_out_valid <= 1'b1;
      r_out_p     <= mul_p;
      r_out_err   <= 1'b0;
    end else if (w_to_hit) begin
      r_out_valid <= 1'b1;
      r_out_p     <= '0;
      r_out_err   <= 1'b1;
    end else if (r_state == S_HOLD && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign mul_x     = r_mul_x;
  assign mul_y     = r_mul_y;
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Directed bench for booth_issue_ctrl with a latency-programmable multiplier model.
module tb_booth_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        mul_start;
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic        mul_done = 1'b0;
  logic [15:0] mul_p = '0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        out_err;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  booth_issue_ctrl #(.N(8), .DEPTH(4), .TO_SLACK(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_done(mul_done), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Multiplier model: captures operands on start, answers m_lat cycles later.
  int               m_lat     = 9;
  logic             m_en      = 1'b1;
  logic             m_busy    = 1'b0;
  int               m_cnt     = 0;
  int               m_starts  = 0;
  int               m_overlap = 0;
  logic signed [7:0] m_x = '0;
  logic signed [7:0] m_y = '0;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (mul_start) begin
      m_starts <= m_starts + 1;
      if (m_busy) m_overlap <= m_overlap + 1;
      m_busy <= 1'b1;
      m_cnt  <= m_lat;
      m_x    <= mul_x;
      m_y    <= mul_y;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        if (m_en) begin
          mul_done <= 1'b1;
          mul_p    <= $signed({{8{m_x[7]}}, m_x}) * $signed({{8{m_y[7]}}, m_y});
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  logic [15:0] res_p[$];
  logic        res_e[$];

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) begin
      res_p.push_back(out_p);
      res_e.push_back(out_err);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before 300000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y);
    int g;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    g = 0;
    while (!in_ready && g < 300) begin
      tick();
      g++;
    end
    if (g >= 300) chk("push_timeout", 32'(g), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input string tag);
    int g;
    g = 0;
    while (res_p.size() < target && g < 500) begin
      tick();
      g++;
    end
    chk(tag, 32'(res_p.size()), 32'(target));
  endtask

  initial begin
    int q0;
    int s0;
    int g;
    int bad;
    int cyc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_x",     32'(mul_x),     32'd0);
    chk("rst_mul_y",     32'(mul_y),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p",     32'(out_p),     32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    reset = 1'b0;
    tick();

    // 1: single job 3 * -5
    m_lat = 9; m_en = 1'b1; out_ready = 1'b1;
    q0 = res_p.size(); s0 = m_starts;
    push(8'h03, 8'hFB);
    chk("t1_no_start_yet", 32'(mul_start), 32'd0);
    tick();
    chk("t1_start",  32'(mul_start), 32'd1);
    chk("t1_mul_x",  32'(mul_x),     32'h03);
    chk("t1_mul_y",  32'(mul_y),     32'hFB);
    tick();
    chk("t1_start_pulse", 32'(mul_start), 32'd0);
    g = 0;
    while (!mul_done && g < 50) begin tick(); g++; end
    chk("t1_done_seen", 32'(mul_done), 32'd1);
    chk("t1_vld_before", 32'(out_valid), 32'd0);
    tick();
    chk("t1_vld_after", 32'(out_valid), 32'd1);
    chk("t1_out_p",     32'(out_p),     32'hFFF1);
    chk("t1_out_err",   32'(out_err),   32'd0);
    tick();
    chk("t1_nres",   32'(res_p.size() - q0), 32'd1);
    chk("t1_starts", 32'(m_starts - s0),     32'd1);

    // 2: five pairs stream in; four queue behind the one in flight
    q0 = res_p.size(); s0 = m_starts;
    push(8'h01, 8'h02);
    push(8'hFF, 8'h01);
    push(8'h07, 8'hF9);
    push(8'h64, 8'h03);
    push(8'hEC, 8'hEC);
    chk("t2_full", 32'(in_ready), 32'd0);
    wait_results(q0 + 5, "t2_nres");
    chk("t2_r0", 32'(res_p[q0]),   32'h0002);
    chk("t2_r1", 32'(res_p[q0+1]), 32'hFFFF);
    chk("t2_r2", 32'(res_p[q0+2]), 32'hFFCF);
    chk("t2_r3", 32'(res_p[q0+3]), 32'h012C);
    chk("t2_r4", 32'(res_p[q0+4]), 32'h0190);
    tick();
    chk("t2_starts",  32'(m_starts - s0), 32'd5);
    chk("t2_overlap", 32'(m_overlap),     32'd0);
    chk("t2_ready",   32'(in_ready),      32'd1);

    // 3: consumer stalls for 10 cycles while a second job is queued
    out_ready = 1'b0;
    q0 = res_p.size();
    push(8'h06, 8'h07);
    g = 0;
    while (!out_valid && g < 50) begin tick(); g++; end
    chk("t3_vld", 32'(out_valid), 32'd1);
    chk("t3_p",   32'(out_p),     32'h002A);
    push(8'h02, 8'h02);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_p !== 16'h002A || mul_start !== 1'b0) bad++;
      tick();
    end
    chk("t3_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t3_issue_after_accept", 32'(mul_start), 32'd1);
    chk("t3_mul_x",              32'(mul_x),     32'h02);
    chk("t3_vld_cleared",        32'(out_valid), 32'd0);
    wait_results(q0 + 2, "t3_nres");
    chk("t3_r0", 32'(res_p[q0]),   32'h002A);
    chk("t3_r1", 32'(res_p[q0+1]), 32'h0004);

    // 4: reset during WAIT with two operand pairs queued
    tick();
    q0 = res_p.size();
    push(8'h09, 8'h09);
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_in_ready", 32'(in_ready),  32'd1);
    chk("t4_start",    32'(mul_start), 32'd0);
    chk("t4_mul_x",    32'(mul_x),     32'd0);
    chk("t4_mul_y",    32'(mul_y),     32'd0);
    chk("t4_vld",      32'(out_valid), 32'd0);
    chk("t4_out_p",    32'(out_p),     32'd0);
    s0 = m_starts;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("t4_no_result", 32'(bad),                32'd0);
    chk("t4_nres",      32'(res_p.size() - q0),  32'd0);
    chk("t4_no_start",  32'(m_starts - s0),      32'd0);

    // 5: signed extremes
    q0 = res_p.size();
    push(8'h80, 8'h80);
    push(8'h80, 8'h7F);
    wait_results(q0 + 2, "t5_nres");
    chk("t5_r0", 32'(res_p[q0]),   32'h4000);
    chk("t5_r1", 32'(res_p[q0+1]), 32'hC080);
    tick();

    // 6: multiplier never answers
    m_en = 1'b0;
`ifdef BOOTH_TIMEOUT_EN
    q0 = res_p.size();
    push(8'h05, 8'h05);
    tick();
    chk("t6_start", 32'(mul_start), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    chk("t6_latency", 32'(cyc),       32'd13);
    chk("t6_err",     32'(out_err),   32'd1);
    chk("t6_p",       32'(out_p),     32'd0);
    m_en = 1'b1;
    push(8'h04, 8'hFD);
    wait_results(q0 + 2, "t6_nres");
    chk("t6_r1",     32'(res_p[q0+1]), 32'hFFF4);
    chk("t6_r1_err", 32'(res_e[q0+1]), 32'd0);
`else
    push(8'h05, 8'h05);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) cyc++;
    end
    chk("t6_waits_forever", 32'(cyc),     32'd0);
    chk("t6_err_tied",      32'(out_err), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_en = 1'b1;
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
